// File: rtl/board_update_if.sv
// Move-request and board-export bundle between the game controller and the
// board writer. The controller drives the request side; the writer returns
// status, flip count and the flat board image.
interface board_update_if #(
   parameter int NCELL = 64
);
   logic                 start;
   logic                 new_game;
   logic [2:0]           row;
   logic [2:0]           col;
   logic [1:0]           player;
   logic                 busy;
   logic                 done;
   logic                 valid;
   logic [5:0]           flip_count;
   logic                 redraw_req;
   logic [2*NCELL-1:0]   board_q;

   modport master (
      output start, new_game, row, col, player,
      input  busy, done, valid, flip_count, redraw_req, board_q
   );

   modport slave (
      input  start, new_game, row, col, player,
      output busy, done, valid, flip_count, redraw_req, board_q
   );
endinterface

// File: rtl/board_update.sv
// Othello board writer: owns the 64-cell board, validates one move per
// request, walks the eight rays from the target, flips bracketed opponent
// runs one cell per cycle and places the mover's piece on commit.
module board_update #(
   parameter int NCELL = 64
) (
   input  logic           clock,
   input  logic           resetn,
   board_update_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE, CHECK, SCAN, FLIP, NEXTDIR, COMMIT, DONE
   } state_t;

   function automatic logic [2*NCELL-1:0] opening_board();
      logic [2*NCELL-1:0] b;
      b = '0;
      b[2*27 +: 2] = 2'b10;
      b[2*36 +: 2] = 2'b10;
      b[2*28 +: 2] = 2'b01;
      b[2*35 +: 2] = 2'b01;
      return b;
   endfunction

   localparam logic [2*NCELL-1:0] OPENING = opening_board();

   // Row step per direction, N first then clockwise; 4-bit two's complement.
   function automatic logic [3:0] step_r(input logic [2:0] d);
      case (d)
         3'd0, 3'd1, 3'd7: step_r = 4'hF;
         3'd2, 3'd6:       step_r = 4'h0;
         default:          step_r = 4'h1;
      endcase
   endfunction

   // Column step per direction.
   function automatic logic [3:0] step_c(input logic [2:0] d);
      case (d)
         3'd1, 3'd2, 3'd3: step_c = 4'h1;
         3'd0, 3'd4:       step_c = 4'h0;
         default:          step_c = 4'hF;
      endcase
   endfunction

   state_t             r_state, w_state_next;
   logic [2*NCELL-1:0] r_board, w_board_next;
   logic [2:0]         r_row, w_row_next;
   logic [2:0]         r_col, w_col_next;
   logic [1:0]         r_player, w_player_next;
   logic [2:0]         r_dir, w_dir_next;
   logic [2:0]         r_run, w_run_next;
   logic [3:0]         r_pr, w_pr_next;
   logic [3:0]         r_pc, w_pc_next;
   logic [5:0]         r_flip, w_flip_next;
   logic               r_valid, w_valid_next;
   logic               r_done, w_done_next;
   logic               r_redraw, w_redraw_next;
   logic               r_busy, w_busy_next;

   logic [5:0] w_tgt_idx;
   logic [5:0] w_pos_idx;
   logic [1:0] w_tgt_cell;
   logic [1:0] w_pos_cell;
   logic       w_off;
   logic       w_player_ok;
   logic       w_tgt_empty;
   logic       w_own;
   logic       w_opp;
   logic [2:0] w_dir_inc;

   // Values 0..7 keep bit 3 clear; -1 and 8 both set it, so bit 3 flags off-board.
   assign w_tgt_idx   = {r_row, r_col};
   assign w_pos_idx   = {r_pr[2:0], r_pc[2:0]};
   assign w_tgt_cell  = r_board[{w_tgt_idx, 1'b0} +: 2];
   assign w_pos_cell  = r_board[{w_pos_idx, 1'b0} +: 2];
   assign w_off       = r_pr[3] | r_pc[3];
   assign w_player_ok = (r_player == 2'b01) || (r_player == 2'b10);
   assign w_tgt_empty = (w_tgt_cell[0] == w_tgt_cell[1]);
   assign w_own       = (w_pos_cell == r_player);
   assign w_opp       = (w_pos_cell == ~r_player);
   assign w_dir_inc   = r_dir + 3'd1;

   // State register; an asynchronous reset abandons any move in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state decision.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (!bus.new_game && bus.start) w_state_next = CHECK;
         CHECK:   w_state_next = (!w_tgt_empty || !w_player_ok) ? DONE : SCAN;
         SCAN: begin
            if (w_off)                          w_state_next = NEXTDIR;
            else if (w_opp)                     w_state_next = SCAN;
            else if (w_own && (r_run != 3'd0))  w_state_next = FLIP;
            else                                w_state_next = NEXTDIR;
         end
         FLIP:    if (r_run == 3'd1) w_state_next = NEXTDIR;
         NEXTDIR: w_state_next = (r_dir == 3'd7) ? COMMIT : SCAN;
         COMMIT:  w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath and output updates for the current state.
   always_comb begin
      w_board_next  = r_board;
      w_row_next    = r_row;
      w_col_next    = r_col;
      w_player_next = r_player;
      w_dir_next    = r_dir;
      w_run_next    = r_run;
      w_pr_next     = r_pr;
      w_pc_next     = r_pc;
      w_flip_next   = r_flip;
      w_valid_next  = r_valid;
      w_done_next   = 1'b0;
      w_redraw_next = 1'b0;
      w_busy_next   = (w_state_next != IDLE);
      case (r_state)
         IDLE: begin
            if (bus.new_game) begin
               w_board_next = OPENING;
            end else if (bus.start) begin
               w_row_next    = bus.row;
               w_col_next    = bus.col;
               w_player_next = bus.player;
               w_flip_next   = 6'd0;
               w_valid_next  = 1'b0;
            end
         end
         CHECK: begin
            w_valid_next = 1'b0;
            w_dir_next   = 3'd0;
            w_run_next   = 3'd0;
            w_pr_next    = {1'b0, r_row} + step_r(3'd0);
            w_pc_next    = {1'b0, r_col} + step_c(3'd0);
         end
         SCAN: begin
            if (!w_off && w_opp) begin
               w_run_next = r_run + 3'd1;
               w_pr_next  = r_pr + step_r(r_dir);
               w_pc_next  = r_pc + step_c(r_dir);
            end else if (!w_off && w_own && (r_run != 3'd0)) begin
               // Step back onto the last opponent cell of the run.
               w_pr_next = r_pr - step_r(r_dir);
               w_pc_next = r_pc - step_c(r_dir);
            end
         end
         FLIP: begin
            w_board_next[{w_pos_idx, 1'b0} +: 2] = r_player;
            w_flip_next = (r_flip == 6'h3F) ? r_flip : r_flip + 6'd1;
            w_run_next  = r_run - 3'd1;
            w_pr_next   = r_pr - step_r(r_dir);
            w_pc_next   = r_pc - step_c(r_dir);
         end
         NEXTDIR: begin
            if (r_dir != 3'd7) begin
               w_dir_next = w_dir_inc;
               w_run_next = 3'd0;
               w_pr_next  = {1'b0, r_row} + step_r(w_dir_inc);
               w_pc_next  = {1'b0, r_col} + step_c(w_dir_inc);
            end
         end
         COMMIT: begin
            if (r_flip != 6'd0) begin
               w_board_next[{w_tgt_idx, 1'b0} +: 2] = r_player;
               w_valid_next = 1'b1;
            end else begin
               w_valid_next = 1'b0;
            end
         end
         DONE: begin
            w_done_next   = 1'b1;
            w_redraw_next = r_valid;
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs; reset restores the opening position.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_board  <= OPENING;
         r_row    <= 3'd0;
         r_col    <= 3'd0;
         r_player <= 2'b00;
         r_dir    <= 3'd0;
         r_run    <= 3'd0;
         r_pr     <= 4'd0;
         r_pc     <= 4'd0;
         r_flip   <= 6'd0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_redraw <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_board  <= w_board_next;
         r_row    <= w_row_next;
         r_col    <= w_col_next;
         r_player <= w_player_next;
         r_dir    <= w_dir_next;
         r_run    <= w_run_next;
         r_pr     <= w_pr_next;
         r_pc     <= w_pc_next;
         r_flip   <= w_flip_next;
         r_valid  <= w_valid_next;
         r_done   <= w_done_next;
         r_redraw <= w_redraw_next;
         r_busy   <= w_busy_next;
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.valid      = r_valid;
   assign bus.flip_count = r_flip;
   assign bus.redraw_req = r_redraw;
   assign bus.board_q    = r_board;
endmodule

// File: tb/tb_board_update.sv
// Scoreboard bench for board_update: stimulus pushes the expected move
// result, a negedge monitor pops it whenever done pulses.
module tb_board_update;
   localparam int MAXCYC = 160;

   typedef struct {
      logic         v;
      logic [5:0]   fc;
      logic         rd;
      logic [127:0] b;
   } exp_t;

   logic clock;
   logic resetn;
   int   checks;
   int   errors;
   exp_t q[$];

   board_update_if bus ();

   board_update dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [127:0] set_cell(input logic [127:0] b, input int i, input logic [1:0] v);
      logic [127:0] r;
      r = b;
      r[2*i +: 2] = v;
      return r;
   endfunction

   function automatic logic [127:0] opening();
      logic [127:0] b;
      b = '0;
      b = set_cell(b, 27, 2'b10);
      b = set_cell(b, 36, 2'b10);
      b = set_cell(b, 28, 2'b01);
      b = set_cell(b, 35, 2'b01);
      return b;
   endfunction

   // Behavioural move: rays are evaluated on the pre-move board.
   function automatic void model(input logic [127:0] b, input int r, input int c, input logic [1:0] p,
                                 output logic [127:0] nb, output logic v, output int fl);
      int dra[8];
      int dca[8];
      logic [1:0] opp;
      dra = '{-1, -1, 0, 1, 1, 1, 0, -1};
      dca = '{0, 1, 1, 1, 0, -1, -1, -1};
      nb = b;
      v  = 1'b0;
      fl = 0;
      if (!(p == 2'b01 || p == 2'b10)) return;
      if (b[2*(r*8+c) +: 2] == 2'b01 || b[2*(r*8+c) +: 2] == 2'b10) return;
      opp = ~p;
      for (int d = 0; d < 8; d++) begin
         int rr = r + dra[d];
         int cc = c + dca[d];
         int n = 0;
         while (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && b[2*(rr*8+cc) +: 2] == opp) begin
            n++;
            rr += dra[d];
            cc += dca[d];
         end
         if (n > 0 && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && b[2*(rr*8+cc) +: 2] == p) begin
            for (int k = 1; k <= n; k++)
               nb[2*((r + k*dra[d])*8 + (c + k*dca[d])) +: 2] = p;
            fl += n;
         end
      end
      if (fl > 0) begin
         nb[2*(r*8+c) +: 2] = p;
         v = 1'b1;
      end else begin
         nb = b;
      end
   endfunction

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      if (resetn) begin
         if (bus.redraw_req) check("redraw_only_with_done", {127'd0, bus.done}, 128'd1);
         if (bus.done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no move result pending");
            end else begin
               exp_t e;
               e = q.pop_front();
               $display("move result: valid=%0d flips=%0d redraw=%0d", bus.valid, bus.flip_count, bus.redraw_req);
               check("valid", {127'd0, bus.valid}, {127'd0, e.v});
               check("flip_count", {122'd0, bus.flip_count}, {122'd0, e.fc});
               check("redraw_req", {127'd0, bus.redraw_req}, {127'd0, e.rd});
               check("board", bus.board_q, e.b);
            end
         end
      end
   end

   // Issue one move and wait for done; n is the number of edges after the start edge.
   task automatic do_move(input int r, input int c, input logic [1:0] p, input logic ev,
                          input logic [5:0] efc, input logic [127:0] eb, output int n);
      exp_t e;
      logic got;
      e.v = ev; e.fc = efc; e.rd = ev; e.b = eb;
      q.push_back(e);
      @(negedge clock);
      bus.start  = 1'b1;
      bus.row    = r[2:0];
      bus.col    = c[2:0];
      bus.player = p;
      @(posedge clock);
      #1 bus.start = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < MAXCYC) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (bus.done) got = 1'b1;
      end
      check("done_within_maxcyc", {127'd0, got}, 128'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] b;
      logic [127:0] nb;
      logic         v;
      int           fl;
      int           n;
      checks = 0;
      errors = 0;
      resetn       = 1'b0;
      bus.start    = 1'b0;
      bus.new_game = 1'b0;
      bus.row      = 3'd0;
      bus.col      = 3'd0;
      bus.player   = 2'b00;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      check("reset_board", bus.board_q, opening());
      check("reset_busy", {127'd0, bus.busy}, 128'd0);
      check("reset_done", {127'd0, bus.done}, 128'd0);
      check("reset_flip", {122'd0, bus.flip_count}, 128'd0);
      check("reset_valid", {127'd0, bus.valid}, 128'd0);

      // Black at (2,3): flips 27 going south
      b = set_cell(set_cell(opening(), 19, 2'b01), 27, 2'b01);
      do_move(2, 3, 2'b01, 1'b1, 6'd1, b, n);

      // White at (2,2): flips 27 going south-east
      b = set_cell(set_cell(b, 18, 2'b10), 27, 2'b10);
      do_move(2, 2, 2'b10, 1'b1, 6'd1, b, n);

      // Occupied target: rejected in CHECK, done two edges after start
      do_move(3, 3, 2'b10, 1'b0, 6'd0, b, n);
      check("reject_latency", n, 2);

      // Empty corner with nothing to flip
      do_move(0, 0, 2'b01, 1'b0, 6'd0, b, n);

      // Black at (4,5) flips 36; start/new_game pulses while busy are ignored
      b = set_cell(set_cell(b, 36, 2'b01), 37, 2'b01);
      begin
         exp_t e;
         logic got;
         e.v = 1'b1; e.fc = 6'd1; e.rd = 1'b1; e.b = b;
         q.push_back(e);
         @(negedge clock);
         bus.start = 1'b1; bus.row = 3'd4; bus.col = 3'd5; bus.player = 2'b01;
         @(posedge clock);
         #1 bus.start = 1'b0;
         @(negedge clock);
         check("busy_during_move", {127'd0, bus.busy}, 128'd1);
         bus.start = 1'b1; bus.new_game = 1'b1; bus.row = 3'd0; bus.col = 3'd0;
         repeat (3) @(posedge clock);
         #1 bus.start = 1'b0;
         bus.new_game = 1'b0;
         n = 0;
         got = 1'b0;
         while (!got && n < MAXCYC) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (bus.done) got = 1'b1;
         end
         check("busy_move_done", {127'd0, got}, 128'd1);
      end

      // new_game and start together in IDLE: reload only
      @(negedge clock);
      bus.new_game = 1'b1; bus.start = 1'b1; bus.row = 3'd2; bus.col = 3'd3; bus.player = 2'b01;
      @(posedge clock);
      #1 bus.new_game = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("newgame_busy_low", {127'd0, bus.busy}, 128'd0);
      end
      check("newgame_board", bus.board_q, opening());

      // Reset while the single flip of (2,3) is in progress
      @(negedge clock);
      bus.start = 1'b1; bus.row = 3'd2; bus.col = 3'd3; bus.player = 2'b01;
      @(posedge clock);
      #1 bus.start = 1'b0;
      repeat (11) @(posedge clock);
      #1 resetn = 1'b0;
      #1;
      check("midflip_reset_board", bus.board_q, opening());
      check("midflip_reset_busy", {127'd0, bus.busy}, 128'd0);
      check("midflip_reset_flip", {122'd0, bus.flip_count}, 128'd0);
      check("midflip_reset_valid", {127'd0, bus.valid}, 128'd0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      check("after_reset_done", {127'd0, bus.done}, 128'd0);
      check("after_reset_board", bus.board_q, opening());

      // 60-move sequence mixing legal moves, random targets and bad colours
      b = opening();
      for (int it = 0; it < 60; it++) begin
         int r;
         int c;
         logic [1:0] p;
         int legal[$];
         p = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         if (it % 10 == 9) p = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         r = $urandom_range(0, 7);
         c = $urandom_range(0, 7);
         if (it % 3 != 2) begin
            legal.delete();
            for (int i = 0; i < 64; i++) begin
               model(b, i / 8, i % 8, p, nb, v, fl);
               if (v) legal.push_back(i);
            end
            if (legal.size() > 0) begin
               int k;
               k = legal[$urandom_range(0, legal.size() - 1)];
               r = k / 8;
               c = k % 8;
            end
         end
         model(b, r, c, p, nb, v, fl);
         if (fl > 63) fl = 63;
         do_move(r, c, p, v, fl[5:0], nb, n);
         b = nb;
      end

      repeat (3) @(negedge clock);
      check("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
